logic_axi4_stream_mux_arbiter: RTL and testbench
================================================

Name: logic_axi4_stream_mux_arbiter

Overview:
- Packet-aware round-robin arbiter that drives the select of the AXI4-Stream N:1 mux tree.
- Sits beside the mux and observes per-input tvalid/tlast and output tready.
- Issues a registered one-hot grant and binary select, locked for a whole packet (up to tlast).
- Gates rx tready / tx tvalid so only the granted input transfers.

Parameters:
- INPUTS, 4, number of requesters; must be >= 1.
- USE_TLAST, 1, 1: grant held until the tlast beat is accepted. 0: every beat is a packet, so round-robin runs per beat.
- SELECT_WIDTH, (INPUTS >= 2) ? $clog2(INPUTS) : 1, width of the select output.

Ports:
- aclk  input  1  clock. One clock; all logic on the rising edge.
- areset  input  1  reset. Reset is synchronous and active-high.
- enable  input  INPUTS  per-input arbitration mask; 1 = may be granted.
- rx_tvalid  input  INPUTS  tvalid of each mux input.
- rx_tlast  input  INPUTS  tlast of each mux input; ignored when USE_TLAST=0.
- rx_tready  output  INPUTS  tready returned to each mux input.
- tx_tready  input  1  tready from mux output sink.
- tx_tvalid  output  1  tvalid presented to mux output sink.
- grant  output  INPUTS  registered one-hot grant; all zero when idle.
- select  output  SELECT_WIDTH  registered binary index of the granted input; drives the mux select.
- locked  output  1  1 while a packet is in progress (state LOCKED).

Behaviour:
- States:
  - IDLE: no grant.
  - LOCKED: grant valid, packet in progress.
- Reset (areset=1 at a clock edge):
  - state=IDLE, grant=0, select=0, locked=0.
  - Round-robin pointer last=INPUTS-1, so input 0 has the highest priority first.
  - Combinational outputs follow: tx_tvalid=0, rx_tready=0.
  - Reset mid-packet abandons the packet. No beat is accepted in the reset cycle.
- Request vector: req = rx_tvalid & enable.
- Round-robin choice: the first set bit of req scanning last+1, last+2, ... modulo INPUTS. The last-granted input has the lowest priority.
- IDLE:
  - If req!=0, register grant/select = choice, locked=1, go to LOCKED.
  - Latency is 1 cycle: a request in cycle t gives tx_tvalid no earlier than cycle t+1.
  - If req==0, stay in IDLE.
- LOCKED with granted index g:
  - tx_tvalid = rx_tvalid[g].
  - rx_tready[g] = tx_tready; all other rx_tready = 0.
  - beat = rx_tvalid[g] & tx_tready.
  - end = beat & (rx_tlast[g] | USE_TLAST==0).
- On end:
  - last <= g.
  - Re-arbitrate in the same cycle using req with pointer g: if req!=0, load the new grant and stay LOCKED (zero-bubble back-to-back packets); else go to IDLE, grant=0, locked=0.
  - g may be re-granted if it is the only requester.
- No end: grant, select and last hold.
  - tx_tready=0 for any number of cycles holds the state.
  - rx_tvalid[g] dropping between beats does not release the lock.
  - Deasserting enable[g] mid-packet does not release the lock. enable only affects new arbitration.
- INPUTS=1: select is constant 0; grant toggles between 1 and 0 per IDLE/LOCKED as above.
- Invariants: grant is one-hot or zero; select==index(grant) when locked; at most one rx_tready is high; rx_tready=0 whenever not locked.

Test Plan:
1. Rotation: after reset, rx_tvalid=4'b1111, rx_tlast=4'b1111, enable=4'b1111, tx_tready=1 -> tx_tvalid rises in the cycle after the request. Grant sequence is 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no bubbles.
2. Packet lock: input1 sends a 3-beat packet with tx_tready pattern 1,0,1,1 while input2 requests -> grant stays 0010 for 4 cycles. On the tlast beat it switches directly to 0100 next cycle. rx_tready[2]=0 throughout.
3. Mask: enable=4'b1010, all inputs valid with single-beat packets -> grants alternate 0010, 1000 only. rx_tready[0] and rx_tready[2] are never 1.
4. Backpressure and idle: input0 granted, tx_tready=0 for 5 cycles -> grant 0001 holds and rx_tready=0. After the tlast beat is accepted with no other requests -> next cycle grant=0, locked=0, tx_tvalid=0.
5. Reset mid-packet: areset=1 during beat 2 of a 4-beat packet on input2 -> next cycle locked=0, grant=0. After release with all inputs valid, input0 is granted first.
6. USE_TLAST=0, INPUTS=3: inputs 0 and 2 valid continuously with rx_tlast=0 -> grant alternates 001, 100 every accepted beat.

Source files
------------

// File: rtl/logic_axi4_stream_mux_arbiter.sv
// Packet-aware round-robin arbiter for an AXI4-Stream N:1 mux: registered one-hot grant
// and binary select, held from the first beat until the packet's tlast is accepted.
module logic_axi4_stream_mux_arbiter #(
  parameter int INPUTS       = 4,
  parameter bit USE_TLAST    = 1'b1,
  parameter int SELECT_WIDTH = (INPUTS >= 2) ? $clog2(INPUTS) : 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [INPUTS-1:0]       enable,
  input  logic [INPUTS-1:0]       rx_tvalid,
  input  logic [INPUTS-1:0]       rx_tlast,
  output logic [INPUTS-1:0]       rx_tready,
  input  logic                    tx_tready,
  output logic                    tx_tvalid,
  output logic [INPUTS-1:0]       grant,
  output logic [SELECT_WIDTH-1:0] select,
  output logic                    locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, state_n;
  logic [INPUTS-1:0]       grant_n;
  logic [SELECT_WIDTH-1:0] select_n;
  logic [SELECT_WIDTH-1:0] last_ptr, last_ptr_n;
  logic [INPUTS-1:0]       req;
  logic                    g_valid, g_last, beat, pkt_end;

  // First requester strictly after ptr, wrapping; ptr itself is scanned last.
  function automatic logic [SELECT_WIDTH-1:0] rr_pick(input logic [INPUTS-1:0] r,
                                                       input logic [SELECT_WIDTH-1:0] ptr);
    logic                    found;
    logic [SELECT_WIDTH-1:0] pick;
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < INPUTS; j++) begin
      if (!found && r[j] && (SELECT_WIDTH'(j) > ptr)) begin
        pick  = SELECT_WIDTH'(j);
        found = 1'b1;
      end
    end
    for (int j = 0; j < INPUTS; j++) begin
      if (!found && r[j]) begin
        pick  = SELECT_WIDTH'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [INPUTS-1:0] to_onehot(input logic [SELECT_WIDTH-1:0] idx);
    return INPUTS'(1) << idx;
  endfunction

  assign req     = rx_tvalid & enable;
  assign g_valid = |(rx_tvalid & grant);
  assign g_last  = |(rx_tlast & grant);
  assign locked  = (state == LOCKED);
  assign beat    = locked & g_valid & tx_tready;
  assign pkt_end = beat & (g_last | !USE_TLAST);

  // Gating by areset keeps any beat from completing in the cycle that abandons a packet.
  assign tx_tvalid = locked & !areset & g_valid;
  assign rx_tready = (locked && !areset) ? (grant & {INPUTS{tx_tready}}) : '0;

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    select_n   = select;
    last_ptr_n = last_ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          select_n = rr_pick(req, last_ptr);
          grant_n  = to_onehot(select_n);
          state_n  = LOCKED;
        end
      end
      LOCKED: begin
        if (pkt_end) begin
          last_ptr_n = select;
          if (|req) begin
            select_n = rr_pick(req, select);
            grant_n  = to_onehot(select_n);
          end else begin
            state_n  = IDLE;
            grant_n  = '0;
            select_n = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      grant    <= '0;
      select   <= '0;
      last_ptr <= SELECT_WIDTH'(INPUTS - 1);
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      select   <= select_n;
      last_ptr <= last_ptr_n;
    end
  end

endmodule

// File: tb/tb_logic_axi4_stream_mux_arbiter.sv
// Directed bench: 4-input packet-mode arbiter plus a 3-input per-beat instance.
module tb_logic_axi4_stream_mux_arbiter;

  logic       clk;
  logic       areset;
  logic [3:0] en, tv, tl, rr, gr;
  logic [1:0] sel;
  logic       tr, txv, lk;

  logic [2:0] en2, tv2, tl2, rr2, gr2;
  logic [1:0] sel2;
  logic       tr2, txv2, lk2;

  int n_tests = 0;
  int n_fail  = 0;

  logic_axi4_stream_mux_arbiter dut (
    .aclk(clk), .areset(areset), .enable(en), .rx_tvalid(tv), .rx_tlast(tl),
    .rx_tready(rr), .tx_tready(tr), .tx_tvalid(txv), .grant(gr), .select(sel), .locked(lk)
  );

  logic_axi4_stream_mux_arbiter #(.INPUTS(3), .USE_TLAST(1'b0)) dut2 (
    .aclk(clk), .areset(areset), .enable(en2), .rx_tvalid(tv2), .rx_tlast(tl2),
    .rx_tready(rr2), .tx_tready(tr2), .tx_tvalid(txv2), .grant(gr2), .select(sel2), .locked(lk2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] g, input logic l,
                    input logic v, input logic [3:0] r);
    chk({tag, " grant"},     32'(gr),  32'(g));
    chk({tag, " locked"},    32'(lk),  32'(l));
    chk({tag, " tx_tvalid"}, 32'(txv), 32'(v));
    chk({tag, " rx_tready"}, 32'(rr),  32'(r));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    nxt();
    areset = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    logic [2:0] g2;
    areset = 1'b1;
    en = '0; tv = '0; tl = '0; tr = 1'b0;
    en2 = '0; tv2 = '0; tl2 = '0; tr2 = 1'b0;
    nxt();
    nxt();
    st("reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("reset select", 32'(sel), 32'd0);
    chk("reset locked2", 32'(lk2), 32'd0);

    // Rotation with single-beat packets on all inputs
    areset = 1'b0;
    en = 4'b1111; tv = 4'b1111; tl = 4'b1111; tr = 1'b1;
    #1;
    st("t1 idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    nxt();
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      st("t1 rot", g, 1'b1, 1'b1, g);
      chk("t1 select", 32'(sel), 32'(k % 4));
      nxt();
    end

    // Packet lock with a stalled beat while input2 waits
    do_reset();
    tv = 4'b0110; tl = 4'b0000; tr = 1'b1;
    #1;
    st("t2 idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    nxt();
    st("t2 b1", 4'b0010, 1'b1, 1'b1, 4'b0010);
    nxt();
    tr = 1'b0; #1;
    st("t2 stall", 4'b0010, 1'b1, 1'b1, 4'b0000);
    nxt();
    tr = 1'b1; #1;
    st("t2 b2", 4'b0010, 1'b1, 1'b1, 4'b0010);
    nxt();
    tl = 4'b0010; #1;
    st("t2 b3", 4'b0010, 1'b1, 1'b1, 4'b0010);
    nxt();
    tv = 4'b0100; tl = 4'b0000; #1;
    st("t2 switch", 4'b0100, 1'b1, 1'b1, 4'b0100);
    chk("t2 select", 32'(sel), 32'd2);
    nxt();

    // Enable mask restricts rotation to inputs 1 and 3
    do_reset();
    en = 4'b1010; tv = 4'b1111; tl = 4'b1111; tr = 1'b1;
    #1;
    st("t3 idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    nxt();
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      st("t3 mask", g, 1'b1, 1'b1, g);
      chk("t3 masked ready", 32'(rr & 4'b0101), 32'd0);
      nxt();
    end

    // Backpressure, tvalid gap, enable drop mid-packet, then idle
    do_reset();
    en = 4'b1111; tv = 4'b0001; tl = 4'b0001; tr = 1'b0;
    #1;
    st("t4 idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    nxt();
    for (int k = 0; k < 5; k++) begin
      tv = (k == 2) ? 4'b0000 : 4'b0001;
      #1;
      st("t4 hold", 4'b0001, 1'b1, (k == 2) ? 1'b0 : 1'b1, 4'b0000);
      nxt();
    end
    tr = 1'b1; tv = 4'b0001; en = 4'b1110; #1;
    st("t4 last", 4'b0001, 1'b1, 1'b1, 4'b0001);
    nxt();
    tv = 4'b0000; en = 4'b1111; #1;
    st("t4 released", 4'b0000, 1'b0, 1'b0, 4'b0000);
    nxt();

    // Reset in the middle of a packet on input2
    do_reset();
    tv = 4'b0100; tl = 4'b0000; tr = 1'b1;
    #1;
    st("t5 idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    nxt();
    st("t5 b1", 4'b0100, 1'b1, 1'b1, 4'b0100);
    nxt();
    areset = 1'b1; #1;
    chk("t5 rst rx_tready", 32'(rr), 32'd0);
    chk("t5 rst tx_tvalid", 32'(txv), 32'd0);
    nxt();
    areset = 1'b0; tv = 4'b1111; tl = 4'b1111; #1;
    st("t5 after", 4'b0000, 1'b0, 1'b0, 4'b0000);
    nxt();
    st("t5 regrant", 4'b0001, 1'b1, 1'b1, 4'b0001);
    nxt();

    // Per-beat round-robin on the 3-input instance
    en = '0; tv = '0; tl = '0; tr = 1'b0;
    do_reset();
    en2 = 3'b111; tv2 = 3'b101; tl2 = 3'b000; tr2 = 1'b1;
    #1;
    chk("t6 idle grant", 32'(gr2), 32'd0);
    chk("t6 idle locked", 32'(lk2), 32'd0);
    nxt();
    for (int k = 0; k < 3; k++) begin
      g2 = (k % 2 == 0) ? 3'b001 : 3'b100;
      chk("t6 grant", 32'(gr2), 32'(g2));
      chk("t6 select", 32'(sel2), (k % 2 == 0) ? 32'd0 : 32'd2);
      chk("t6 rx_tready", 32'(rr2), 32'(g2));
      chk("t6 tx_tvalid", 32'(txv2), 32'd1);
      nxt();
    end
    tr2 = 1'b0; #1;
    chk("t6 stall grant", 32'(gr2), 32'b100);
    chk("t6 stall ready", 32'(rr2), 32'd0);
    nxt();
    tr2 = 1'b1; #1;
    chk("t6 resume grant", 32'(gr2), 32'b100);
    chk("t6 resume ready", 32'(rr2), 32'b100);
    nxt();
    chk("t6 wrap grant", 32'(gr2), 32'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
